bcd_to_bin_conv: RTL
====================

BCD_TO_BIN_CONV -- requirements
Module: bcd_to_bin_conv

Interface
REQ-001 SHALL have parameter: DIGITS, 8, number of packed BCD digits accepted (1..8).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  in_bcd holds a request.
REQ-005 SHALL have port: in_ready  output  1  block can accept a request.
REQ-006 SHALL have port: in_bcd  input  4*DIGITS  packed BCD, digit 0 in bits [3:0].
REQ-007 SHALL have port: out_valid  output  1  result available.
REQ-008 SHALL have port: out_ready  input  1  consumer takes the result.
REQ-009 SHALL have port: out_bin  output  4*DIGITS  unsigned binary value of in_bcd.
REQ-010 SHALL have port: out_err  output  1  request contained a digit > 9.

Function
REQ-011 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-012 SHALL drive in_ready high only in IDLE.
REQ-013 SHALL accept a request on an edge where in_valid && in_ready; it latches in_bcd into the BCD register, clears the binary register, and loads iteration counter = 4*DIGITS.
REQ-014 SHALL check all digits at acceptance; if any digit > 9, go directly to DONE with out_err=1 and out_bin=0.
REQ-015 SHALL, in SHIFT each cycle, shift {bcd_reg, bin_reg} right by 1 (bcd LSB into bin MSB).
REQ-016 SHALL, in the same cycle after the shift, subtract 3 from every BCD digit whose shifted value is >= 8.
REQ-017 SHALL decrement the counter each SHIFT cycle; when counter reaches 0, go to DONE.
REQ-018 SHALL assert out_valid exactly 4*DIGITS cycles after the acceptance edge for valid input (32 for DIGITS=8); for invalid input it SHALL assert 1 cycle after acceptance.
REQ-019 SHALL hold out_valid, out_bin and out_err stable in DONE until out_valid && out_ready, then return to IDLE on that edge.
REQ-020 SHALL not accept a new request in the cycle the result is consumed; in_ready rises the cycle after.
REQ-021 SHALL ignore in_valid and in_bcd changes while in SHIFT or DONE.
REQ-022 SHALL never overflow: maximum result 10^DIGITS-1 fits in 4*DIGITS bits; upper bits are zero.
REQ-023 SHALL drive out_bin=0 and out_err=0 whenever out_valid is low.

Reset
REQ-024 SHALL, on rst_n low, immediately force IDLE, counter=0, bcd_reg=0, bin_reg=0, out_valid=0, out_err=0, out_bin=0 and in_ready=0.
REQ-025 SHALL abandon any in-flight conversion on reset mid-SHIFT or mid-DONE, with no result produced afterwards.
REQ-026 SHALL raise in_ready on the first rising clk edge after rst_n deasserts.

Structure
REQ-027 SHALL place the state enum type and the BCD_DIGIT_MAX=9 constant in the shared conversion package.
REQ-028 SHALL place the per-digit adjust as a sub-module bcd_digit_adjust (4-bit in, 4-bit out, subtracts 3 when input >= 8), instantiated DIGITS times.
REQ-029 SHALL contain no division, modulo or multiply operators.

Verification
REQ-030 SHALL cover: in_bcd=0x00000000 -> out_bin=0, out_err=0, out_valid 32 cycles after acceptance.
REQ-031 SHALL cover: in_bcd=0x00001234 -> out_bin=0x000004D2.
REQ-032 SHALL cover: in_bcd=0x99999999 -> out_bin=0x05F5E0FF.
REQ-033 SHALL cover: in_bcd=0x000000A1 -> out_err=1, out_bin=0, out_valid one cycle after acceptance.
REQ-034 SHALL cover: out_ready held low 10 cycles in DONE -> outputs stable; in_ready stays low; a new in_valid is ignored.
REQ-035 SHALL cover: rst_n pulsed low at iteration 15 of 0x00005678 -> outputs zero at once; no out_valid until a new request; next request 0x00000042 -> 0x2A.

Source files
------------

// File: rtl/bcd_to_bin_conv_pkg.sv
// bcd_to_bin_conv_pkg: shared FSM state type and BCD digit limit
package bcd_to_bin_conv_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
endpackage

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: reverse double-dabble digit fix, subtracts 3 from digits >= 8
module bcd_digit_adjust (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = d[3] ? d - 4'd3 : d;
endmodule

// File: rtl/bcd_to_bin_conv.sv
// bcd_to_bin_conv: sequential packed-BCD to binary converter (shift-right / subtract-3)
module bcd_to_bin_conv
  import bcd_to_bin_conv_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [(DIGITS<<2)-1:0]  in_bcd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [(DIGITS<<2)-1:0]  out_bin,
  output logic                    out_err
);
  localparam int W  = DIGITS << 2;
  localparam int CW = $clog2(W + 1);
  state_t         state;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   bcd_reg, bin_reg, bcd_sh, bin_sh, bcd_adj;
  logic [DIGITS-1:0] bad;
  assign bcd_sh = {1'b0, bcd_reg[W-1:1]};
  assign bin_sh = {bcd_reg[0], bin_reg[W-1:1]};
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit_adjust u_adj (.d(bcd_sh[(i<<2)+:4]), .q(bcd_adj[(i<<2)+:4]));
    assign bad[i] = in_bcd[(i<<2)+:4] > BCD_DIGIT_MAX;
  end
  // Control FSM: accept, iterate W shift/adjust steps, hold result until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bcd_reg   <= '0;
      bin_reg   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            bcd_reg  <= in_bcd;
            bin_reg  <= '0;
            cnt      <= CW'(W);
            if (|bad) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_err   <= 1'b1;
              out_bin   <= '0;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          bcd_reg <= bcd_adj;
          bin_reg <= bin_sh;
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_bin   <= bin_sh;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_bin   <= '0;
            out_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
